// File: rtl/undo_stack.sv
`default_nettype none
// ============================================================================
//  Module   : undo_stack
//  Purpose  : Undo-history stack for reverse execution. Push, pop, replace-top,
//             commit-clear, wrapping peek, occupancy count and sticky
//             overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module undo_stack #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter bit MODE_WRAP  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   input  logic                  commit,
   input  logic [DEPTH_LOG2-1:0] peek_off,
   output logic [WIDTH-1:0]      peek_data,
   output logic                  peek_valid,
   output logic [WIDTH-1:0]      top_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_DEPTH  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] C_CNT1   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0] C_CNT0   = '0;
   localparam logic [DEPTH_LOG2-1:0] C_SP1  = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] sp_q, sp_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic                  we;
   logic [DEPTH_LOG2-1:0] waddr;
   logic [DEPTH_LOG2-1:0] top_addr;
   logic [DEPTH_LOG2-1:0] peek_addr;

   assign top_addr  = sp_q - C_SP1;
   // Offset subtraction wraps within the pointer width by construction.
   assign peek_addr = top_addr - peek_off;

   // Next-state decode; one priority row applies per cycle.
   always_comb begin
      sp_d    = sp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we      = 1'b0;
      waddr   = sp_q;
      if (commit) begin
         // History discarded; sp kept so stale entries are simply invalid.
         count_d = C_CNT0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (push && pop) begin
         if (count_q != C_CNT0) begin
            we    = 1'b1;
            waddr = top_addr;
         end else begin
            // Pop side underflows; the push still lands on an empty stack.
            we      = 1'b1;
            sp_d    = sp_q + C_SP1;
            count_d = count_q + C_CNT1;
            unf_d   = 1'b1;
         end
      end else if (push) begin
         if (count_q != C_DEPTH) begin
            we      = 1'b1;
            sp_d    = sp_q + C_SP1;
            count_d = count_q + C_CNT1;
         end else begin
            ovf_d = 1'b1;
            if (MODE_WRAP) begin
               // Overwrites the oldest slot, which is exactly where sp points.
               we   = 1'b1;
               sp_d = sp_q + C_SP1;
            end
         end
      end else if (pop) begin
         if (count_q != C_CNT0) begin
            sp_d    = sp_q - C_SP1;
            count_d = count_q - C_CNT1;
         end else begin
            unf_d = 1'b1;
         end
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Entry storage; deliberately not reset, validity comes from count only.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= push_data;
      end
   end

   assign top_data   = mem_q[top_addr];
   assign peek_data  = mem_q[peek_addr];
   assign peek_valid = ({1'b0, peek_off} < count_q);
   assign count      = count_q;
   assign empty      = (count_q == C_CNT0);
   assign full       = (count_q == C_DEPTH);
   assign overflow   = ovf_q;
   assign underflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_undo_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_undo_stack
//  Purpose  : Directed self-checking bench for undo_stack, run on a wrapping
//             and a rejecting instance driven by identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_undo_stack;

   logic        clk = 1'b0;
   logic        reset;
   logic        push, pop, commit;
   logic [15:0] push_data;
   logic [1:0]  peek_off;

   logic [15:0] w_peek, w_top, n_peek, n_top;
   logic        w_pv, w_empty, w_full, w_ovf, w_unf;
   logic        n_pv, n_empty, n_full, n_ovf, n_unf;
   logic [2:0]  w_count, n_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   undo_stack #(.WIDTH(16), .DEPTH_LOG2(2), .MODE_WRAP(1'b1)) dut_wrap (
      .clk(clk), .reset(reset), .push(push), .push_data(push_data),
      .pop(pop), .commit(commit), .peek_off(peek_off),
      .peek_data(w_peek), .peek_valid(w_pv), .top_data(w_top),
      .count(w_count), .empty(w_empty), .full(w_full),
      .overflow(w_ovf), .underflow(w_unf)
   );

   undo_stack #(.WIDTH(16), .DEPTH_LOG2(2), .MODE_WRAP(1'b0)) dut_rej (
      .clk(clk), .reset(reset), .push(push), .push_data(push_data),
      .pop(pop), .commit(commit), .peek_off(peek_off),
      .peek_data(n_peek), .peek_valid(n_pv), .top_data(n_top),
      .count(n_count), .empty(n_empty), .full(n_full),
      .overflow(n_ovf), .underflow(n_unf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0; pop = 1'b0; commit = 1'b0;
   endtask

   task automatic do_push(input logic [15:0] d);
      push = 1'b1; pop = 1'b0; commit = 1'b0; push_data = d;
      tick();
      idle();
   endtask

   task automatic do_commit();
      push = 1'b0; pop = 1'b0; commit = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      reset = 1'b1; idle(); push_data = '0; peek_off = '0;
      #12;
      chk("rst_count", 32'(w_count), 32'd0);
      chk("rst_empty", 32'(w_empty), 32'd1);
      chk("rst_full",  32'(w_full),  32'd0);
      chk("rst_ovf",   32'(w_ovf),   32'd0);
      chk("rst_unf",   32'(w_unf),   32'd0);
      chk("rst_pv",    32'(w_pv),    32'd0);
      reset = 1'b0;
      tick();

      // Scenario 1: three pushes, peek depth and validity.
      do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
      chk("s1_count", 32'(w_count), 32'd3);
      chk("s1_top",   32'(w_top),   32'h3333);
      peek_off = 2'd2; #1;
      chk("s1_peek2", 32'(w_peek),  32'h1111);
      chk("s1_pv2",   32'(w_pv),    32'd1);
      peek_off = 2'd3; #1;
      chk("s1_pv3",   32'(w_pv),    32'd0);
      peek_off = 2'd0;

      // Scenario 2: five pushes into four slots, wrap versus reject.
      do_commit();
      chk("s2_clr", 32'(w_count), 32'd0);
      for (int i = 0; i < 5; i++) do_push(16'hA000 + 16'(i));
      chk("s2w_count", 32'(w_count), 32'd4);
      chk("s2w_full",  32'(w_full),  32'd1);
      chk("s2w_ovf",   32'(w_ovf),   32'd1);
      for (int i = 0; i < 4; i++) begin
         peek_off = 2'(i); #1;
         chk($sformatf("s2w_peek%0d", i), 32'(w_peek), 32'hA004 - 32'(i));
      end
      peek_off = 2'd0; #1;
      chk("s2n_top",   32'(n_top),   32'hA003);
      chk("s2n_count", 32'(n_count), 32'd4);
      chk("s2n_ovf",   32'(n_ovf),   32'd1);
      peek_off = 2'd3; #1;
      chk("s2n_peek3", 32'(n_peek),  32'hA000);
      peek_off = 2'd0;

      // Scenario 3: simultaneous push and pop replaces the top.
      do_commit();
      chk("s3_ovfclr", 32'(w_ovf), 32'd0);
      do_push(16'h0001); do_push(16'h0002);
      push = 1'b1; pop = 1'b1; push_data = 16'hBEEF;
      tick(); idle();
      chk("s3_count", 32'(w_count), 32'd2);
      chk("s3_top",   32'(w_top),   32'hBEEF);
      peek_off = 2'd1; #1;
      chk("s3_peek1", 32'(w_peek),  32'h0001);
      peek_off = 2'd0;
      // Plain pop: value visible in the pop cycle, count drops at the edge.
      pop = 1'b1; #1;
      chk("s3_popval", 32'(w_top), 32'hBEEF);
      tick(); idle();
      chk("s3_popcnt", 32'(w_count), 32'd1);
      chk("s3_poptop", 32'(w_top),   32'h0001);

      // Scenario 4: pop on empty sets underflow, commit clears it.
      do_commit();
      pop = 1'b1; tick(); idle();
      chk("s4_unf",   32'(w_unf),   32'd1);
      chk("s4_count", 32'(w_count), 32'd0);
      do_commit();
      chk("s4_unfclr", 32'(w_unf), 32'd0);

      // Push+pop on empty: acts as a push and flags underflow.
      push = 1'b1; pop = 1'b1; push_data = 16'h4242;
      tick(); idle();
      chk("s4b_count", 32'(w_count), 32'd1);
      chk("s4b_top",   32'(w_top),   32'h4242);
      chk("s4b_unf",   32'(w_unf),   32'd1);

      // Scenario 5: commit wins over a same-cycle push.
      do_commit();
      do_push(16'h0101); do_push(16'h0202); do_push(16'h0303);
      push = 1'b1; commit = 1'b1; push_data = 16'h5555;
      tick(); idle();
      chk("s5_count", 32'(w_count), 32'd0);
      chk("s5_empty", 32'(w_empty), 32'd1);
      do_push(16'h7777);
      chk("s5_count1", 32'(w_count), 32'd1);
      chk("s5_top",    32'(w_top),   32'h7777);

      // Scenario 6: asynchronous reset between edges.
      do_push(16'h8888); do_push(16'h9999);
      pop = 1'b1; push = 1'b1; push_data = 16'h6666;
      chk("s6_pre", 32'(w_count), 32'd3);
      #2 reset = 1'b1;
      #1;
      chk("s6_count", 32'(w_count), 32'd0);
      chk("s6_empty", 32'(w_empty), 32'd1);
      chk("s6_ovf",   32'(w_ovf),   32'd0);
      chk("s6_unf",   32'(w_unf),   32'd0);
      tick(); idle();
      chk("s6_held", 32'(w_count), 32'd0);
      reset = 1'b0;
      do_push(16'hC0DE);
      chk("s6_post_cnt", 32'(w_count), 32'd1);
      chk("s6_post_top", 32'(w_top),   32'hC0DE);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/undo_stack.md
# undo_stack

Parametrised undo-history stack for the reversible AXA pipeline: stores the values that push-class instructions (and land's pre-jump PC) save on forward execution, and supplies them back during reverse execution. It sits beside the register-read stage; that stage pushes, pops and peeks at a wrapping offset from the top of the stack. Compared with the fixed 16-entry in-processor buffer, this block adds:
- parametrised width and depth;
- selectable full behaviour (wrap or reject);
- occupancy tracking, which the raw pointer cannot provide;
- sticky overflow/underflow flags;
- a commit clear for `com`.

## Interface
- `WIDTH`, 16, entry width in bits.
- `DEPTH_LOG2`, 4, log2 of entry count; DEPTH = 2^DEPTH_LOG2.
- `MODE_WRAP`, 1, 1 = push when full overwrites the oldest entry; 0 = push when full is rejected.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous active-high reset.
- `push`  in  1  push `push_data` this cycle.
- `push_data`  in  WIDTH  value to push.
- `pop`  in  1  remove the top entry this cycle.
- `commit`  in  1  discard all history (`com`).
- `peek_off`  in  DEPTH_LOG2  offset below top; 0 = top.
- `peek_data`  out  WIDTH  entry at top − `peek_off`; combinational.
- `peek_valid`  out  1  `peek_off` < `count`; combinational.
- `top_data`  out  WIDTH  current top entry; equals `peek_data` at offset 0.
- `count`  out  DEPTH_LOG2+1  valid entries, 0..DEPTH.
- `empty`  out  1  `count` == 0.
- `full`  out  1  `count` == DEPTH.
- `overflow`  out  1  sticky; a push occurred while full.
- `underflow`  out  1  sticky; a pop occurred while empty.

## Operation
State:
- `sp`: DEPTH_LOG2-bit write pointer; wraps modulo DEPTH.
- `count`: saturates at DEPTH.
- storage: DEPTH × WIDTH; not reset.

Entry addressing:
- Top entry is at address `sp`−1 mod DEPTH.
- Peek address is `sp`−1−`peek_off` mod DEPTH; the subtraction is clipped to DEPTH_LOG2 bits.

Per-cycle priority (exactly one row applies):
1. `commit` = 1:
   - `count` ← 0; `overflow` ← 0; `underflow` ← 0.
   - `sp` is unchanged.
   - `push` and `pop` are ignored this cycle.
2. `push` & `pop`, `count` > 0 (replace top):
   - mem[`sp`−1] ← `push_data`.
   - `sp` and `count` are unchanged.
3. `push` & `pop`, `count` == 0:
   - Treated as a push.
   - `underflow` ← 1.
4. `push` only, `count` < DEPTH:
   - mem[`sp`] ← `push_data`; `sp` ← `sp`+1; `count` ← `count`+1.
5. `push` only, `count` == DEPTH:
   - `overflow` ← 1.
   - If MODE_WRAP = 1: write as in row 4, but `count` stays DEPTH; the oldest entry is lost.
   - If MODE_WRAP = 0: no write, and `sp` is unchanged.
6. `pop` only, `count` > 0:
   - `sp` ← `sp`−1; `count` ← `count`−1.
7. `pop` only, `count` == 0:
   - `underflow` ← 1.
   - `sp` is unchanged.
8. No request: hold all state.

Read-side rules:
- `top_data` and `peek_data` reflect the state before the edge. A popped value must be sampled in the same cycle that `pop` is asserted.
- `peek_data` for an invalid offset is whatever storage holds. The consumer must qualify it with `peek_valid`.
- Entries are never cleared by pop or commit; only `count` governs validity.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `sp` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0, `peek_valid` = 0.
  - `top_data` and `peek_data` are unspecified.
- Reset deassertion mid-operation: the first rising edge with `reset` low processes requests normally. Requests present while `reset` is high are lost.
- Push latency: one cycle. A value pushed at edge N is visible on `top_data`, and on `peek_data` at offset 0, after edge N.
- Pop latency: zero-cycle read. `count` and `sp` update at the edge.
- `count`, `empty`, `full` and the flags are registered and change only at rising edges.
- `empty` and `full` are decoded from the registered `count`.
- Sustained one-request-per-cycle throughput, with no stall output.

## Test plan
All scenarios use WIDTH = 16, DEPTH_LOG2 = 2.

1. Push 0x1111, 0x2222, 0x3333 on consecutive cycles:
   - After the third edge: `count` = 3, `top_data` = 0x3333.
   - `peek_off` = 2 → 0x1111, `peek_valid` = 1.
   - `peek_off` = 3 → `peek_valid` = 0.
2. Push 0xA000..0xA004 (five pushes) with MODE_WRAP = 1:
   - Final state: `count` = 4, `full` = 1, `overflow` = 1.
   - Peek offsets 0..3 return 0xA004, 0xA003, 0xA002, 0xA001.
   - Same stimulus with MODE_WRAP = 0: `top_data` = 0xA003, `sp` = 0.
3. From 2 entries [0x0001, 0x0002], assert `push` = 1, `pop` = 1, `push_data` = 0xBEEF:
   - `count` stays 2, `top_data` = 0xBEEF.
   - The peek at offset 1 still returns 0x0001.
4. Pop on empty: `underflow` = 1 and `count` = 0. A following `commit` clears `underflow`.
5. With 3 entries, `commit` together with `push` in the same cycle: the push is dropped, `count` = 0 and `empty` = 1. The next push of 0x7777 gives `count` = 1 and `top_data` = 0x7777.
6. Reset mid-stream: assert `reset` between clock edges with `count` = 3. `count` = 0 and the flags read 0 immediately, before the next edge.
